// File: rtl/iob_jbi_pkg.sv
// iob_jbi_pkg: shared widths and skid-state encodings for the IOB->JBI path
package iob_jbi_pkg;
  localparam int IOB_JBI_DW = 136;
  localparam int IOB_JBI_CW = 16;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} skid_state_e;
endpackage

// File: rtl/iob_jbi_sat_cnt.sv
// iob_jbi_sat_cnt: CW-bit saturating up-counter with async active-low clear
module iob_jbi_sat_cnt #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          en,
  output logic [CW-1:0] cnt
);
  // count up while enabled, holding at all-ones
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) cnt <= '0;
    else if (en && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/iob_jbi_skid_stage.sv
// iob_jbi_skid_stage: two-entry registered skid stage; IOB_JBI_SKID_PARITY_EN adds per-entry parity check
module iob_jbi_skid_stage
  import iob_jbi_pkg::*;
#(
  parameter int DW = IOB_JBI_DW,
  parameter int CW = IOB_JBI_CW
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          in_vld,
  input  logic [DW-1:0] in_data,
  output logic          in_rdy,
  output logic          out_vld,
  output logic [DW-1:0] out_data,
  input  logic          out_rdy,
  output logic [1:0]    occ,
  output logic [CW-1:0] stall_cnt,
  output logic          par_err
);
  skid_state_e state_q, state_d;
  logic [DW-1:0] main_q, skid_q;
  logic in_xfer, out_xfer, ld_main_in, ld_main_skid, ld_skid;
  assign in_xfer = in_vld && in_rdy;
  assign out_xfer = out_vld && out_rdy;
  assign ld_main_in = in_xfer && (state_q == EMPTY || out_xfer);
  assign ld_main_skid = state_q == FULL && out_xfer;
  assign ld_skid = state_q == ONE && in_xfer && !out_xfer;
  assign out_data = main_q;
  assign occ = state_q;
  // next occupancy from the two transfer strobes
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   state_d = in_xfer ? ONE : EMPTY;
      ONE:     state_d = (in_xfer && !out_xfer) ? FULL : (out_xfer && !in_xfer) ? EMPTY : ONE;
      default: state_d = out_xfer ? ONE : FULL;
    endcase
  end
  // state, registered handshakes and entry data; ready/valid come from next state only
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      state_q <= EMPTY;
      in_rdy  <= 1'b0;
      out_vld <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      in_rdy  <= state_d != FULL;
      out_vld <= state_d != EMPTY;
      if (ld_main_in) main_q <= in_data;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid) skid_q <= in_data;
    end
`ifdef IOB_JBI_SKID_PARITY_EN
  logic main_par_q, skid_par_q;
  // even parity stored alongside each entry, rechecked on the presented word
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      main_par_q <= 1'b0;
      skid_par_q <= 1'b0;
      par_err    <= 1'b0;
    end else begin
      if (ld_main_in) main_par_q <= ^in_data;
      else if (ld_main_skid) main_par_q <= skid_par_q;
      if (ld_skid) skid_par_q <= ^in_data;
      if (out_vld && (^main_q != main_par_q)) par_err <= 1'b1;
    end
`else
  assign par_err = 1'b0;
`endif
  iob_jbi_sat_cnt #(.CW(CW)) u_stall_cnt (
    .clk   (clk),
    .rst_l (rst_l),
    .en    (out_vld && !out_rdy),
    .cnt   (stall_cnt)
  );
endmodule

// File: tb/tb_iob_jbi_skid_stage.sv
// tb_iob_jbi_skid_stage: scoreboard bench for iob_jbi_skid_stage (CW=4)
module tb_iob_jbi_skid_stage;
  localparam int DW = 136;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  logic in_vld = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_rdy, out_vld, out_rdy, par_err;
  logic [DW-1:0] out_data;
  logic [1:0] occ;
  logic [CW-1:0] stall_cnt;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] pkt_a, pkt_b;
  int n_chk = 0, n_fail = 0, exp_stall = 0;
  bit up = 0;
  always #5 clk = ~clk;
  iob_jbi_skid_stage #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst_l(rst_l), .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
    .out_vld(out_vld), .out_data(out_data), .out_rdy(out_rdy), .occ(occ),
    .stall_cnt(stall_cnt), .par_err(par_err)
  );
  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r);
    int sz;
    bit push, pop;
    in_vld = v;
    in_data = d;
    out_rdy = r;
    #1;
    sz = sb.size();
    check("occ", DW'(occ), DW'(sz));
    check("in_rdy", DW'(in_rdy), DW'(up && sz < 2));
    check("out_vld", DW'(out_vld), DW'(sz > 0));
    check("stall_cnt", DW'(stall_cnt), DW'(exp_stall));
    check("par_err", DW'(par_err), '0);
    if (sz > 0) check("out_data", out_data, sb[0]);
    push = v && up && sz < 2;
    pop = r && sz > 0;
    if (sz > 0 && !r && exp_stall < 15) exp_stall++;
    if (pop) void'(sb.pop_front());
    if (push) sb.push_back(d);
    up = 1;
    @(negedge clk);
  endtask
  task automatic drain();
    for (int i = 0; i < 8 && sb.size() > 0; i++) cycle(1'b0, '0, 1'b1);
    check("drain_empty", DW'(sb.size()), '0);
  endtask
  initial begin
    out_rdy = 1'b0;
    pkt_a = {8'hA5, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
    pkt_b = {8'h5A, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555};
    #1;
    check("rst_in_rdy", DW'(in_rdy), '0);
    check("rst_out_vld", DW'(out_vld), '0);
    check("rst_out_data", out_data, '0);
    check("rst_occ", DW'(occ), '0);
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    cycle(1'b0, '0, 1'b1);
    cycle(1'b1, DW'(1), 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, DW'(i), 1'b1);
    drain();
    cycle(1'b1, pkt_a, 1'b0);
    cycle(1'b1, pkt_b, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, ~pkt_a, 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b1, pkt_a, 1'b0);
    cycle(1'b1, pkt_b, 1'b1);
    cycle(1'b0, '0, 1'b0);
    drain();
    cycle(1'b1, DW'(77), 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0);
    check("stall_sat", DW'(stall_cnt), DW'(15));
    drain();
    cycle(1'b1, pkt_a, 1'b0);
    cycle(1'b1, pkt_b, 1'b0);
    check("pre_rst_occ", DW'(occ), DW'(2));
    #2;
    rst_l = 1'b0;
    #1;
    check("mid_rst_in_rdy", DW'(in_rdy), '0);
    check("mid_rst_out_vld", DW'(out_vld), '0);
    check("mid_rst_out_data", out_data, '0);
    check("mid_rst_occ", DW'(occ), '0);
    check("mid_rst_stall", DW'(stall_cnt), '0);
    sb.delete();
    exp_stall = 0;
    up = 0;
    @(negedge clk);
    rst_l = 1'b1;
    cycle(1'b0, '0, 1'b1);
    cycle(1'b1, DW'(1), 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
`ifdef IOB_JBI_SKID_PARITY_EN
    cycle(1'b1, pkt_a, 1'b0);
    force dut.main_q[3] = ~pkt_a[3];
    @(negedge clk);
    release dut.main_q[3];
    @(negedge clk);
    check("par_err_set", DW'(par_err), DW'(1));
    out_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("par_err_sticky", DW'(par_err), DW'(1));
    rst_l = 1'b0;
    #1;
    check("par_err_rst", DW'(par_err), '0);
    rst_l = 1'b1;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/iob_jbi_skid_stage.md
Name: iob_jbi_skid_stage

Overview:
- Registered 136-bit pipeline stage with valid/ready handshake on the IOB→JBI datapath.
- Sits directly upstream of the 136-bit IOB→JBI wire repeater and drives its input.
- Breaks the timing path on both data/valid (forward) and ready (backward).
- Two-entry skid buffer gives full throughput with a registered ready.

Parameters:
- DW, 136, payload width in bits; must match the downstream repeater width.
- CW, 16, width of the stall/occupancy counter.

Ports:
- clk  input  1  stage clock; single clock domain.
- rst_l  input  1  asynchronous active-low reset.
- in_vld  input  1  upstream data valid.
- in_data  input  DW  upstream payload.
- in_rdy  output  1  stage can accept; registered.
- out_vld  output  1  output payload valid; registered.
- out_data  output  DW  payload to the repeater input; registered.
- out_rdy  input  1  downstream accept.
- occ  output  2  current entry count, 0..2.
- stall_cnt  output  CW  saturating count of cycles with out_vld=1 and out_rdy=0.

Behaviour:
- Reset:
  - rst_l is asynchronous and active-low; clk is the only clock.
  - On assertion: in_rdy=0, out_vld=0, out_data=0, occ=0, stall_cnt=0.
  - in_rdy rises on the first clk edge after rst_l deasserts.
  - Data registers are also cleared; no X may propagate.
- Transfers:
  - Input transfer happens when in_vld & in_rdy at a clk edge.
  - Output transfer happens when out_vld & out_rdy at a clk edge.
- States (2-bit encoding, also driven on occ):
  - EMPTY (occ=0): in_rdy=1, out_vld=0.
    - Input transfer → load main register → ONE.
  - ONE (occ=1): in_rdy=1, out_vld=1, out_data=main register.
    - Input and output transfer together → main register takes in_data; stay ONE.
    - Input transfer only → in_data goes to skid register → FULL.
    - Output transfer only → EMPTY.
  - FULL (occ=2): in_rdy=0, out_vld=1, out_data=main register.
    - Output transfer → skid register moves to main register → ONE.
    - in_vld is ignored while in FULL.
- Latency and ordering:
  - Latency from input transfer to out_vld is 1 cycle when EMPTY.
  - Packets leave in strict FIFO order; none is dropped or duplicated.
  - Sustained throughput is 1 packet per cycle when out_rdy is held at 1.
- Handshake rules:
  - Once out_vld=1, out_data is held stable until the output transfer.
  - in_rdy depends only on registered state; no combinational path from out_rdy.
- stall_cnt:
  - Increments each cycle with out_vld=1 and out_rdy=0.
  - Saturates at 2^CW-1; no wrap-around.
- Reset mid-operation discards all buffered entries immediately, with no partial output.

Optional Feature:
- Macro IOB_JBI_SKID_PARITY_EN.
- When defined:
  - Even parity over in_data is computed on entry and stored per entry as a 1-bit extension.
  - Parity is rechecked on out_data whenever out_vld=1.
  - A mismatch sets sticky output par_err (1 bit, cleared only by reset).
  - Data still flows unmodified.
- When not defined:
  - No parity storage.
  - par_err port is present but tied to 0.

Decomposition:
- Shared package iob_jbi_pkg holds:
  - IOB_JBI_DW = 136.
  - State encodings EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
  - Counter width default 16.
- One sub-module, iob_jbi_sat_cnt: generic CW-bit saturating counter with increment enable and async active-low clear.
- The skid control and the data registers stay in the top module.

Test Plan:
- Reset then streaming:
  - Stimulus: assert rst_l=0 mid-stream with occ=2, then release; then in_vld=1 with data 136'h1 for 1 cycle, out_rdy=1.
  - Response: all outputs 0 during reset, in_rdy=1 on the next edge after release; out_vld=1 with out_data=136'h1 one cycle later, then EMPTY.
- Back-to-back throughput:
  - Stimulus: 8 packets with incrementing values 0..7, in_vld=1 and out_rdy=1 every cycle.
  - Response: 8 outputs on consecutive cycles, in order, occ stays at 1.
- Backpressure fill:
  - Stimulus: out_rdy=0 while sending packets A and B.
  - Response: occ=2, in_rdy=0, out_data=A stable, stall_cnt increments each cycle.
  - Then out_rdy=1: A, then B on the next cycle; in_rdy returns to 1 after the first output transfer.
- Simultaneous in/out in ONE:
  - Stimulus: in ONE, assert in_vld and out_rdy in the same cycle.
  - Response: old data transfers out, new data is in the main register, occ stays 1.
- Saturation:
  - Stimulus: with CW=4, hold out_vld=1 and out_rdy=0 for 20 cycles.
  - Response: stall_cnt reaches 15 and stays at 15.
- Parity (IOB_JBI_SKID_PARITY_EN defined):
  - Stimulus: force a single bit flip in the stored main register.
  - Response: par_err=1 on the next cycle and remains set until reset.
